// File: rtl/lvl_state_pkg.sv
// Shared definitions for the level-states BRAM: FSM encoding and entry packing.
// Used by lvl_state_writer and by the backtrack-level search that reads the entries.
package lvl_state_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PUSH  = 2'd1,
    ST_CLEAR = 2'd2,
    ST_DONE  = 2'd3
  } lvl_state_t;

  localparam int HAS_BKT_BIT = 0;
  localparam int BIN_OFS     = 1;

  // Entries are handled at 32 bits so any instance width can cast down.
  function automatic logic [31:0] pack_entry(input logic [31:0] bin, input logic has_bkt);
    return (bin << BIN_OFS) | {31'd0, has_bkt};
  endfunction

  function automatic logic [31:0] entry_bin(input logic [31:0] entry);
    return entry >> BIN_OFS;
  endfunction

  function automatic logic entry_has_bkt(input logic [31:0] entry);
    return entry[HAS_BKT_BIT];
  endfunction

endpackage

// File: rtl/lvl_state_writer.sv
// Write side of the level-states BRAM: records decisions, zeroes levels on backtrack.
// Define LVL_CLEAR_ON_BKT_EN to zero abandoned entries; otherwise backtrack only lowers top.
module lvl_state_writer
  import lvl_state_pkg::*;
#(
  parameter int WIDTH_LVL              = 16,
  parameter int WIDTH_BIN_ID           = 10,
  parameter int WIDTH_LVL_STATES       = 11,
  parameter int ADDR_WIDTH_LVLS_STATES = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_push,
  input  logic [WIDTH_LVL-1:0]              push_lvl_i,
  input  logic [WIDTH_BIN_ID-1:0]           push_bin_i,
  input  logic                              start_clear,
  input  logic [WIDTH_LVL-1:0]              clear_lvl_i,
  output logic                              done_o,
  output logic                              busy_o,
  output logic                              apply_store_o,
  output logic                              overflow_o,
  output logic [WIDTH_LVL-1:0]              top_lvl_o,
  output logic                              ram_we_l_state_o,
  output logic [WIDTH_LVL_STATES-1:0]       ram_data_l_state_o,
  output logic [ADDR_WIDTH_LVLS_STATES-1:0] ram_addr_l_state_o
);

  lvl_state_t            state;
  logic [WIDTH_LVL-1:0]  push_lvl;
  logic [WIDTH_BIN_ID-1:0] push_bin;
  logic [WIDTH_LVL-1:0]  top_lvl;
  logic                  overflow;
  logic                  push_fits;
`ifdef LVL_CLEAR_ON_BKT_EN
  localparam logic [WIDTH_LVL-1:0] ONE = WIDTH_LVL'(1);
  logic [WIDTH_LVL-1:0]  cnt;
  logic [WIDTH_LVL-1:0]  clr_lvl;
`endif

  // Any set bit above the address field would alias onto a lower level.
  assign push_fits = (push_lvl >> ADDR_WIDTH_LVLS_STATES) == '0;

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      push_lvl <= '0;
      push_bin <= '0;
      top_lvl  <= '0;
      overflow <= 1'b0;
`ifdef LVL_CLEAR_ON_BKT_EN
      cnt      <= '0;
      clr_lvl  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_clear) begin
`ifdef LVL_CLEAR_ON_BKT_EN
            if (clear_lvl_i < top_lvl) begin
              state   <= ST_CLEAR;
              cnt     <= top_lvl;
              clr_lvl <= clear_lvl_i;
            end else begin
              state <= ST_DONE;
            end
`else
            if (clear_lvl_i < top_lvl) top_lvl <= clear_lvl_i;
            state <= ST_DONE;
`endif
          end else if (start_push) begin
            state    <= ST_PUSH;
            push_lvl <= push_lvl_i;
            push_bin <= push_bin_i;
          end
        end
        ST_PUSH: begin
          if (push_fits) top_lvl <= push_lvl;
          else           overflow <= 1'b1;
          state <= ST_DONE;
        end
`ifdef LVL_CLEAR_ON_BKT_EN
        ST_CLEAR: begin
          cnt <= cnt - ONE;
          // L+1 is the last level zeroed; root level 0 is therefore never touched.
          if (cnt == clr_lvl + ONE) begin
            top_lvl <= clr_lvl;
            state   <= ST_DONE;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so they cannot glitch on input changes.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    ram_we_l_state_o   = 1'b0;
    ram_data_l_state_o = '0;
    ram_addr_l_state_o = '0;
    if (state == ST_PUSH && push_fits) begin
      ram_we_l_state_o   = 1'b1;
      ram_data_l_state_o = WIDTH_LVL_STATES'(pack_entry(32'(push_bin), 1'b0));
      ram_addr_l_state_o = ADDR_WIDTH_LVLS_STATES'(push_lvl);
    end
`ifdef LVL_CLEAR_ON_BKT_EN
    if (state == ST_CLEAR) begin
      ram_we_l_state_o   = 1'b1;
      ram_addr_l_state_o = ADDR_WIDTH_LVLS_STATES'(cnt);
    end
`endif
  end

  assign done_o        = (state == ST_DONE);
  assign busy_o        = (state != ST_IDLE);
  assign apply_store_o = (state == ST_PUSH) || (state == ST_CLEAR);
  assign overflow_o    = overflow;
  assign top_lvl_o     = top_lvl;

endmodule
